decode_pipe: RTL and testbench
==============================

# decode_pipe

Parametrised, pipelined CHIP-8 instruction decoder between the fetch unit and the execute unit. Accepts instructions as 16-bit words or as two 8-bit memory beats (high byte first), classifies them into the full CHIP-8 opcode set plus optional SUPER-CHIP extensions, and delivers decoded records through a DEPTH-entry queue with valid/ready handshakes on both sides. A flush input discards in-flight work on taken branches.

## Interface
- `BYTE_IN`, 0: 0 = one 16-bit word per beat; 1 = two 8-bit beats per instruction, high byte first.
- `SCHIP_EN`, 0: 1 = decode SUPER-CHIP opcodes; 0 = treat them as `SYS`/`ILLEGAL`.
- `ADDR_W`, 12: width of `nnn`; must be ≥12; `instr[11:0]` is zero-extended.
- `DEPTH`, 2: output queue entries; power of two, ≥2.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous discard of the queue and any pending high byte.
- `in_valid`  in  1  input beat valid.
- `in_data`  in  16  beat; only `[7:0]` used when `BYTE_IN`=1.
- `in_ready`  out  1  beat accepted when `in_valid && in_ready`.
- `out_valid`  out  1  decoded record available.
- `out_ready`  in  1  consumer takes record when `out_valid && out_ready`.
- `op`  out  6  opcode class (`OP_*`).
- `x`, `y`, `n`  out  4 each  `instr[11:8]`, `[7:4]`, `[3:0]`.
- `kk`  out  8  `instr[7:0]`.
- `nnn`  out  ADDR_W  zero-extended `instr[11:0]`.
- `illegal`  out  1  high iff `op == OP_ILLEGAL`.
- `instr`  out  16  raw assembled instruction.

## Operation
- Fields are extracted for every instruction regardless of class.
- Classification: `00E0` CLS, `00EE` RET, other `0nnn` SYS; `1nnn` JP; `2nnn` CALL; `3xkk` SE_VK; `4xkk` SNE_VK; `5xy0` SE_VV; `6xkk` LD_VK; `7xkk` ADD_VK; `8xy0..7,E` LD_VV/OR/AND/XOR/ADD_VV/SUB/SHR/SUBN/SHL; `9xy0` SNE_VV; `Annn` LD_I; `Bnnn` JP_V0; `Cxkk` RND; `Dxyn` DRW; `Ex9E` SKP; `ExA1` SKNP; `Fx07/0A/15/18/1E/29/33/55/65` LD_VX_DT/LD_VX_K/LD_DT_VX/LD_ST_VX/ADD_I_VX/LD_F/LD_B/ST_REGS/LD_REGS.
- With `SCHIP_EN`=1, these decode first: `00Cn` SCD, `00FB` SCR, `00FC` SCL, `00FD` EXIT, `00FE` LOW, `00FF` HIGH, `Fx30` LD_HF, `Fx75` ST_RPL, `Fx85` LD_RPL. With `SCHIP_EN`=0, `00Cn`/`00Fx` are SYS and `Fx30/75/85` are ILLEGAL.
- Everything else is ILLEGAL: `5xyn`/`9xyn` with n≠0, `8xy8..D,F`, other `Ex`/`Fx` low bytes. An ILLEGAL record is still queued with `illegal`=1; it is never dropped.
- Byte assembly (`BYTE_IN`=1) uses a two-state FSM:
  - `HI`: an accepted beat latches the high byte and moves to `LO`.
  - `LO`: an accepted beat forms `{hi, beat}`, decodes it, pushes it, and returns to `HI`.
  - A high byte may be accepted while the queue is full. The low byte is accepted only when the queue is not full.
- Queue: a FIFO holds decoded records. `out_*` present the head entry. Pop on `out_valid && out_ready`. In the same cycle, push and pop are both allowed when not full.
- Flush, when high: empties the queue, returns the FSM to `HI`, and discards any beat accepted in the same cycle. Flush takes priority over push and pop.

## Timing
- Reset (`rst`=0, asynchronous): queue empty, FSM in `HI`, `out_valid`=0, all record outputs 0 (`op`=OP_ILLEGAL encoding 0, so `illegal` reads 0 during reset). `in_ready`=0 while in reset.
- `in_ready`:
  - `BYTE_IN`=0: `!full`.
  - `BYTE_IN`=1: `(state==HI) || !full`.
  - In both modes it is combinational from registered state only, with no path from `in_valid`.
- Latency: the record is visible on `out_*` with `out_valid`=1 in the cycle after the accepting edge of the word or low byte. There is no bypass when the queue is empty.
- Throughput: one record per cycle in word mode, one per two cycles in byte mode.
- While full, a pop frees a slot on the following cycle. `in_ready` does not look ahead at `out_ready`.
- Record outputs hold stable while `out_valid && !out_ready`.

## Structure
- Shared package `chip8_pkg`:
  - `OP_W`=6.
  - `OP_*` constants: ILLEGAL=0, then in the order listed above starting at CLS=1, SYS, JP…LD_REGS, with SCHIP classes last.
  - The decoded-record field widths.
- Sub-module `decode_fifo` (generic WIDTH/DEPTH synchronous FIFO with flush, full/empty, async active-low reset).
- The classifier is a combinational function inside `decode_pipe`.

## Test plan
- Word mode, DEPTH=2: push `00E0`, `D125`, `F833` back-to-back with `out_ready`=1 → CLS (x=0); DRW (x=1, y=2, n=5); LD_B (x=8) on consecutive cycles, each one cycle after acceptance.
- `out_ready`=0, push `1ABC`, `2DEF`, `6107` → `in_ready` drops after 2; the third is held until the first pop; `nnn`=0xABC, then 0xDEF, then LD_VK with kk=0x07.
- Illegal sweep: `5121`, `812F`, `E1FF`, `F1FF`, `F130` with SCHIP_EN=0 → all ILLEGAL with `illegal`=1; `00FF` → SYS.
- SCHIP_EN=1: `00C4` → SCD with n=4; `00FF` → HIGH; `F275` → ST_RPL with x=2.
- BYTE_IN=1: beats 0x8A, 0xBE → SHL with x=A, y=B one cycle after the second beat. Then beat 0x12, flush, beats 0x30, 0x05 → only SE_VK with x=0, kk=0x05 emerges.
- Reset mid-operation: with 2 records queued, assert `rst` asynchronously between edges → `out_valid`=0 immediately; after release the first beat decodes correctly.

Source files
------------

// File: rtl/chip8_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | chip8_pkg                                                                |
// | Opcode class encodings and decoded-record layout shared by the decoder.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package chip8_pkg;

  localparam int OP_W    = 6;
  localparam int NIB_W   = 4;
  localparam int BYTE_W  = 8;
  localparam int INSTR_W = 16;

  localparam logic [OP_W-1:0] OP_ILLEGAL  = 6'd0;
  localparam logic [OP_W-1:0] OP_CLS      = 6'd1;
  localparam logic [OP_W-1:0] OP_RET      = 6'd2;
  localparam logic [OP_W-1:0] OP_SYS      = 6'd3;
  localparam logic [OP_W-1:0] OP_JP       = 6'd4;
  localparam logic [OP_W-1:0] OP_CALL     = 6'd5;
  localparam logic [OP_W-1:0] OP_SE_VK    = 6'd6;
  localparam logic [OP_W-1:0] OP_SNE_VK   = 6'd7;
  localparam logic [OP_W-1:0] OP_SE_VV    = 6'd8;
  localparam logic [OP_W-1:0] OP_LD_VK    = 6'd9;
  localparam logic [OP_W-1:0] OP_ADD_VK   = 6'd10;
  localparam logic [OP_W-1:0] OP_LD_VV    = 6'd11;
  localparam logic [OP_W-1:0] OP_OR       = 6'd12;
  localparam logic [OP_W-1:0] OP_AND      = 6'd13;
  localparam logic [OP_W-1:0] OP_XOR      = 6'd14;
  localparam logic [OP_W-1:0] OP_ADD_VV   = 6'd15;
  localparam logic [OP_W-1:0] OP_SUB      = 6'd16;
  localparam logic [OP_W-1:0] OP_SHR      = 6'd17;
  localparam logic [OP_W-1:0] OP_SUBN     = 6'd18;
  localparam logic [OP_W-1:0] OP_SHL      = 6'd19;
  localparam logic [OP_W-1:0] OP_SNE_VV   = 6'd20;
  localparam logic [OP_W-1:0] OP_LD_I     = 6'd21;
  localparam logic [OP_W-1:0] OP_JP_V0    = 6'd22;
  localparam logic [OP_W-1:0] OP_RND      = 6'd23;
  localparam logic [OP_W-1:0] OP_DRW      = 6'd24;
  localparam logic [OP_W-1:0] OP_SKP      = 6'd25;
  localparam logic [OP_W-1:0] OP_SKNP     = 6'd26;
  localparam logic [OP_W-1:0] OP_LD_VX_DT = 6'd27;
  localparam logic [OP_W-1:0] OP_LD_VX_K  = 6'd28;
  localparam logic [OP_W-1:0] OP_LD_DT_VX = 6'd29;
  localparam logic [OP_W-1:0] OP_LD_ST_VX = 6'd30;
  localparam logic [OP_W-1:0] OP_ADD_I_VX = 6'd31;
  localparam logic [OP_W-1:0] OP_LD_F     = 6'd32;
  localparam logic [OP_W-1:0] OP_LD_B     = 6'd33;
  localparam logic [OP_W-1:0] OP_ST_REGS  = 6'd34;
  localparam logic [OP_W-1:0] OP_LD_REGS  = 6'd35;
  localparam logic [OP_W-1:0] OP_SCD      = 6'd36;
  localparam logic [OP_W-1:0] OP_SCR      = 6'd37;
  localparam logic [OP_W-1:0] OP_SCL      = 6'd38;
  localparam logic [OP_W-1:0] OP_EXIT     = 6'd39;
  localparam logic [OP_W-1:0] OP_LOW      = 6'd40;
  localparam logic [OP_W-1:0] OP_HIGH     = 6'd41;
  localparam logic [OP_W-1:0] OP_LD_HF    = 6'd42;
  localparam logic [OP_W-1:0] OP_ST_RPL   = 6'd43;
  localparam logic [OP_W-1:0] OP_LD_RPL   = 6'd44;

  // Only class and raw word are stored; operand fields are re-sliced at the head.
  typedef struct packed {
    logic                illegal;
    logic [OP_W-1:0]     op;
    logic [INSTR_W-1:0]  instr;
  } dec_rec_t;

  localparam int REC_W = $bits(dec_rec_t);

endpackage
`default_nettype wire

// File: rtl/decode_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | decode_fifo                                                              |
// | Generic synchronous FIFO with flush, full/empty, async active-low reset. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module decode_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign empty    = (r_wr_ptr == r_rd_ptr);
  assign w_push   = push && !full;
  assign w_pop    = pop && !empty;
  assign pop_data = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= push_data;
        r_wr_ptr                <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/decode_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | decode_pipe                                                              |
// | Pipelined CHIP-8 / SUPER-CHIP decoder with word or byte-pair input.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module decode_pipe
  import chip8_pkg::*;
#(
  parameter int BYTE_IN  = 0,
  parameter int SCHIP_EN = 0,
  parameter int ADDR_W   = 12,
  parameter int DEPTH    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [INSTR_W-1:0] in_data,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OP_W-1:0]    op,
  output logic [NIB_W-1:0]   x,
  output logic [NIB_W-1:0]   y,
  output logic [NIB_W-1:0]   n,
  output logic [BYTE_W-1:0]  kk,
  output logic [ADDR_W-1:0]  nnn,
  output logic               illegal,
  output logic [INSTR_W-1:0] instr
);

  function automatic logic [OP_W-1:0] classify(input logic [15:0] w, input logic sc);
    logic [OP_W-1:0] r;
    r = OP_ILLEGAL;
    case (w[15:12])
      4'h0: begin
        if (sc && w[11:4] == 8'h0C)        r = OP_SCD;
        else if (sc && w[11:0] == 12'h0FB) r = OP_SCR;
        else if (sc && w[11:0] == 12'h0FC) r = OP_SCL;
        else if (sc && w[11:0] == 12'h0FD) r = OP_EXIT;
        else if (sc && w[11:0] == 12'h0FE) r = OP_LOW;
        else if (sc && w[11:0] == 12'h0FF) r = OP_HIGH;
        else if (w[11:0] == 12'h0E0)       r = OP_CLS;
        else if (w[11:0] == 12'h0EE)       r = OP_RET;
        else                               r = OP_SYS;
      end
      4'h1: r = OP_JP;
      4'h2: r = OP_CALL;
      4'h3: r = OP_SE_VK;
      4'h4: r = OP_SNE_VK;
      4'h5: if (w[3:0] == 4'h0) r = OP_SE_VV;
      4'h6: r = OP_LD_VK;
      4'h7: r = OP_ADD_VK;
      4'h8: begin
        case (w[3:0])
          4'h0:    r = OP_LD_VV;
          4'h1:    r = OP_OR;
          4'h2:    r = OP_AND;
          4'h3:    r = OP_XOR;
          4'h4:    r = OP_ADD_VV;
          4'h5:    r = OP_SUB;
          4'h6:    r = OP_SHR;
          4'h7:    r = OP_SUBN;
          4'hE:    r = OP_SHL;
          default: r = OP_ILLEGAL;
        endcase
      end
      4'h9: if (w[3:0] == 4'h0) r = OP_SNE_VV;
      4'hA: r = OP_LD_I;
      4'hB: r = OP_JP_V0;
      4'hC: r = OP_RND;
      4'hD: r = OP_DRW;
      4'hE: begin
        case (w[7:0])
          8'h9E:   r = OP_SKP;
          8'hA1:   r = OP_SKNP;
          default: r = OP_ILLEGAL;
        endcase
      end
      4'hF: begin
        case (w[7:0])
          8'h07:   r = OP_LD_VX_DT;
          8'h0A:   r = OP_LD_VX_K;
          8'h15:   r = OP_LD_DT_VX;
          8'h18:   r = OP_LD_ST_VX;
          8'h1E:   r = OP_ADD_I_VX;
          8'h29:   r = OP_LD_F;
          8'h33:   r = OP_LD_B;
          8'h55:   r = OP_ST_REGS;
          8'h65:   r = OP_LD_REGS;
          8'h30:   r = sc ? OP_LD_HF  : OP_ILLEGAL;
          8'h75:   r = sc ? OP_ST_RPL : OP_ILLEGAL;
          8'h85:   r = sc ? OP_LD_RPL : OP_ILLEGAL;
          default: r = OP_ILLEGAL;
        endcase
      end
    endcase
    return r;
  endfunction

  logic               w_full;
  logic               w_empty;
  logic               w_accept;
  logic               w_push;
  logic [INSTR_W-1:0] w_word;
  logic [OP_W-1:0]    w_op;
  dec_rec_t           w_rec_in;
  dec_rec_t           w_head;

  assign w_accept = in_valid && in_ready;

  if (BYTE_IN != 0) begin : g_byte
    localparam logic [0:0] ST_HI = 1'b0;
    localparam logic [0:0] ST_LO = 1'b1;

    logic [0:0]        r_state;
    logic [BYTE_W-1:0] r_hi;
    logic              w_unused_hi;

    assign w_unused_hi = ^in_data[15:8];
    // The high byte never needs a queue slot; only the completing low byte does.
    assign in_ready    = rst && ((r_state == ST_HI) || !w_full);
    assign w_push      = w_accept && (r_state == ST_LO) && !flush;
    assign w_word      = {r_hi, in_data[7:0]};

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_state <= ST_HI;
        r_hi    <= '0;
      end else if (flush) begin
        r_state <= ST_HI;
      end else if (w_accept) begin
        if (r_state == ST_HI) begin
          r_hi    <= in_data[7:0];
          r_state <= ST_LO;
        end else begin
          r_state <= ST_HI;
        end
      end
    end
  end else begin : g_word
    assign in_ready = rst && !w_full;
    assign w_push   = w_accept && !flush;
    assign w_word   = in_data;
  end

  assign w_op             = classify(w_word, SCHIP_EN != 0);
  assign w_rec_in.illegal = (w_op == OP_ILLEGAL);
  assign w_rec_in.op      = w_op;
  assign w_rec_in.instr   = w_word;

  decode_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (w_push),
    .push_data (w_rec_in),
    .pop       (out_valid && out_ready),
    .pop_data  (w_head),
    .full      (w_full),
    .empty     (w_empty)
  );

  assign out_valid = !w_empty;
  assign op        = w_head.op;
  assign illegal   = w_head.illegal;
  assign instr     = w_head.instr;
  assign x         = w_head.instr[11:8];
  assign y         = w_head.instr[7:4];
  assign n         = w_head.instr[3:0];
  assign kk        = w_head.instr[7:0];
  assign nnn       = ADDR_W'(w_head.instr[11:0]);

endmodule
`default_nettype wire

// File: tb/tb_decode_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_decode_pipe                                                           |
// | Scoreboard bench: three decoder variants against a pattern-table model.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_decode_pipe;

  localparam int N = 3;  // 0: word/CHIP-8 D2, 1: word/SCHIP D4 A16, 2: byte/CHIP-8 D2

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [N-1:0]       in_valid  = '0;
  logic [N-1:0]       out_ready = '1;
  logic [N-1:0]       flush     = '0;
  logic [N-1:0][15:0] in_data   = '0;
  wire  [N-1:0]       in_ready, out_valid, illegal;
  wire  [N-1:0][5:0]  op;
  wire  [N-1:0][3:0]  x, y, n;
  wire  [N-1:0][7:0]  kk;
  wire  [N-1:0][15:0] nnn, instr;

  int errors = 0;
  int checks = 0;
  bit tmo    = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int AW = (g == 1) ? 16 : 12;
    wire [AW-1:0] nnn_l;
    decode_pipe #(
      .BYTE_IN  ((g == 2) ? 1 : 0),
      .SCHIP_EN ((g == 1) ? 1 : 0),
      .ADDR_W   (AW),
      .DEPTH    ((g == 1) ? 4 : 2)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush[g]),
      .in_valid  (in_valid[g]),
      .in_data   (in_data[g]),
      .in_ready  (in_ready[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .op        (op[g]),
      .x         (x[g]),
      .y         (y[g]),
      .n         (n[g]),
      .kk        (kk[g]),
      .nnn       (nnn_l),
      .illegal   (illegal[g]),
      .instr     (instr[g])
    );
    assign nnn[g] = 16'(nnn_l);
  end

  function automatic int depth_of(input int d); return (d == 1) ? 4 : 2; endfunction
  function automatic bit byte_of(input int d);  return d == 2;           endfunction
  function automatic bit schip_of(input int d); return d == 1;           endfunction

  // Reference classifier: ordered (mask, match) table, first hit wins.
  logic [15:0] pat_mask[$];
  logic [15:0] pat_match[$];
  int          pat_op[$];
  bit          pat_sc[$];

  task automatic add_pat(input logic [15:0] m, input logic [15:0] v, input int o, input bit sc);
    pat_mask.push_back(m); pat_match.push_back(v); pat_op.push_back(o); pat_sc.push_back(sc);
  endtask

  task automatic build_table();
    add_pat(16'hFFF0, 16'h00C0, 36, 1); add_pat(16'hFFFF, 16'h00FB, 37, 1);
    add_pat(16'hFFFF, 16'h00FC, 38, 1); add_pat(16'hFFFF, 16'h00FD, 39, 1);
    add_pat(16'hFFFF, 16'h00FE, 40, 1); add_pat(16'hFFFF, 16'h00FF, 41, 1);
    add_pat(16'hF0FF, 16'hF030, 42, 1); add_pat(16'hF0FF, 16'hF075, 43, 1);
    add_pat(16'hF0FF, 16'hF085, 44, 1);
    add_pat(16'hFFFF, 16'h00E0, 1, 0);  add_pat(16'hFFFF, 16'h00EE, 2, 0);
    add_pat(16'hF000, 16'h0000, 3, 0);  add_pat(16'hF000, 16'h1000, 4, 0);
    add_pat(16'hF000, 16'h2000, 5, 0);  add_pat(16'hF000, 16'h3000, 6, 0);
    add_pat(16'hF000, 16'h4000, 7, 0);  add_pat(16'hF00F, 16'h5000, 8, 0);
    add_pat(16'hF000, 16'h6000, 9, 0);  add_pat(16'hF000, 16'h7000, 10, 0);
    for (int k = 0; k < 8; k++) add_pat(16'hF00F, 16'h8000 | 16'(k), 11 + k, 0);
    add_pat(16'hF00F, 16'h800E, 19, 0); add_pat(16'hF00F, 16'h9000, 20, 0);
    add_pat(16'hF000, 16'hA000, 21, 0); add_pat(16'hF000, 16'hB000, 22, 0);
    add_pat(16'hF000, 16'hC000, 23, 0); add_pat(16'hF000, 16'hD000, 24, 0);
    add_pat(16'hF0FF, 16'hE09E, 25, 0); add_pat(16'hF0FF, 16'hE0A1, 26, 0);
    add_pat(16'hF0FF, 16'hF007, 27, 0); add_pat(16'hF0FF, 16'hF00A, 28, 0);
    add_pat(16'hF0FF, 16'hF015, 29, 0); add_pat(16'hF0FF, 16'hF018, 30, 0);
    add_pat(16'hF0FF, 16'hF01E, 31, 0); add_pat(16'hF0FF, 16'hF029, 32, 0);
    add_pat(16'hF0FF, 16'hF033, 33, 0); add_pat(16'hF0FF, 16'hF055, 34, 0);
    add_pat(16'hF0FF, 16'hF065, 35, 0);
  endtask

  function automatic int model_op(input logic [15:0] w, input bit sc);
    for (int i = 0; i < pat_op.size(); i++)
      if ((!pat_sc[i] || sc) && ((w & pat_mask[i]) == pat_match[i])) return pat_op[i];
    return 0;
  endfunction

  function automatic logic [15:0] rand_instr();
    logic [15:0] r;
    int          i;
    r = 16'($urandom);
    if ($urandom_range(0, 3) == 0) return r;
    i = $urandom_range(0, pat_op.size() - 1);
    return (r & ~pat_mask[i]) | pat_match[i];
  endfunction

  // Scoreboard state: expected instruction words per DUT plus the byte-pairing model.
  logic [15:0] exp_mem [N][64];
  int          head [N];
  int          tail [N];
  bit          hi_pend [N];
  logic [7:0]  hi_byte [N];

  task automatic chk(input int d, input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s dut%0d t=%0t: got %0h, expected %0h", nm, d, $time, act, req);
    end
  endtask

  // Monitor: compare the presented head, then apply this cycle's handshakes to the model.
  initial begin
    int          sz;
    bit          rdy;
    logic [15:0] w;
    int          o;
    forever begin
      @(negedge clk);
      for (int d = 0; d < N; d++) begin
        if (!rst) begin
          head[d] = 0; tail[d] = 0; hi_pend[d] = 1'b0;
          chk(d, "rst_out_valid", 32'(out_valid[d]), 32'd0);
          chk(d, "rst_in_ready",  32'(in_ready[d]),  32'd0);
          chk(d, "rst_op",        32'(op[d]),        32'd0);
          chk(d, "rst_illegal",   32'(illegal[d]),   32'd0);
          chk(d, "rst_instr",     32'(instr[d]),     32'd0);
        end else begin
          sz  = tail[d] - head[d];
          rdy = byte_of(d) ? (!hi_pend[d] || sz < depth_of(d)) : (sz < depth_of(d));
          chk(d, "in_ready",  32'(in_ready[d]),  32'(rdy));
          chk(d, "out_valid", 32'(out_valid[d]), 32'(sz > 0));
          if (sz > 0 && out_valid[d]) begin
            w = exp_mem[d][head[d] % 64];
            o = model_op(w, schip_of(d));
            chk(d, "op",      32'(op[d]),      32'(o));
            chk(d, "illegal", 32'(illegal[d]), 32'(o == 0));
            chk(d, "instr",   32'(instr[d]),   32'(w));
            chk(d, "x",       32'(x[d]),       32'(w[11:8]));
            chk(d, "y",       32'(y[d]),       32'(w[7:4]));
            chk(d, "n",       32'(n[d]),       32'(w[3:0]));
            chk(d, "kk",      32'(kk[d]),      32'(w[7:0]));
            chk(d, "nnn",     32'(nnn[d]),     32'(w[11:0]));
          end
          if (flush[d]) begin
            head[d] = tail[d];
            hi_pend[d] = 1'b0;
          end else begin
            if (sz > 0 && out_ready[d]) head[d]++;
            if (in_valid[d] && rdy) begin
              if (!byte_of(d)) begin
                exp_mem[d][tail[d] % 64] = in_data[d];
                tail[d]++;
              end else if (!hi_pend[d]) begin
                hi_byte[d] = in_data[d][7:0];
                hi_pend[d] = 1'b1;
              end else begin
                exp_mem[d][tail[d] % 64] = {hi_byte[d], in_data[d][7:0]};
                tail[d]++;
                hi_pend[d] = 1'b0;
              end
            end
          end
        end
      end
      chk(0, "stim_timeout", 32'(tmo), 32'd0);
    end
  end

  task automatic idle(input int c);
    repeat (c) begin @(posedge clk); #1; end
  endtask

  // Present one beat and hold it until accepted (bounded).
  task automatic send(input int d, input logic [15:0] v);
    int k;
    k = 0;
    in_valid[d] = 1'b1;
    in_data[d]  = v;
    do begin @(negedge clk); k++; end while (!in_ready[d] && k < 100);
    if (k >= 100) begin
      tmo = 1'b1;
      $display("FAIL send_timeout dut%0d: got in_ready=0 for %0d cycles, expected acceptance", d, k);
    end
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
  endtask

  initial begin
    bit [N-1:0]  acc;
    bit          ph [N];
    logic [15:0] cur [N];

    build_table();
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk); #1;

    send(0, 16'h00E0); send(0, 16'hD125); send(0, 16'hF833);
    idle(3);

    out_ready[0] = 1'b0;
    send(0, 16'h1ABC); send(0, 16'h2DEF);
    fork
      send(0, 16'h6107);
      begin idle(4); out_ready[0] = 1'b1; end
    join
    idle(4);

    foreach (pat_op[i]) begin end
    send(0, 16'h5121); send(0, 16'h812F); send(0, 16'hE1FF);
    send(0, 16'hF1FF); send(0, 16'hF130); send(0, 16'h00FF);
    idle(3);

    send(1, 16'h00C4); send(1, 16'h00FF); send(1, 16'hF275);
    send(1, 16'hF1FF); send(1, 16'h00EE);
    idle(3);

    send(2, 16'h008A); send(2, 16'h00BE);
    idle(2);
    send(2, 16'h0012);
    flush[2] = 1'b1;
    idle(1);
    flush[2] = 1'b0;
    send(2, 16'h0030); send(2, 16'h0005);
    idle(3);

    // Byte mode with a full queue: the high byte still goes in, the low byte waits.
    out_ready[2] = 1'b0;
    send(2, 16'hFF64); send(2, 16'h0022); send(2, 16'h0070); send(2, 16'h0011);
    send(2, 16'h00A1);
    fork
      send(2, 16'h0023);
      begin idle(5); out_ready[2] = 1'b1; end
    join
    idle(4);

    // Asynchronous reset between edges with two records queued.
    out_ready[0] = 1'b0;
    send(0, 16'h3A55); send(0, 16'h4B66);
    #1 rst = 1'b0;
    idle(2);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    out_ready[0] = 1'b1;
    send(0, 16'hA123);
    idle(3);

    for (int d = 0; d < N; d++) begin ph[d] = 1'b0; cur[d] = 16'h0; end
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      for (int d = 0; d < N; d++) acc[d] = in_valid[d] && in_ready[d];
      @(posedge clk); #1;
      for (int d = 0; d < N; d++) begin
        if (byte_of(d)) begin
          if (flush[d]) ph[d] = 1'b0;
          else if (acc[d]) ph[d] = !ph[d];
        end
        if (acc[d] || !in_valid[d] || flush[d]) begin
          in_valid[d] = ($urandom_range(0, 3) != 0);
          if (!byte_of(d)) in_data[d] = rand_instr();
          else begin
            if (!ph[d]) cur[d] = rand_instr();
            in_data[d] = {8'($urandom), ph[d] ? cur[d][7:0] : cur[d][15:8]};
          end
        end
        out_ready[d] = ($urandom_range(0, 3) != 0);
        flush[d]     = ($urandom_range(0, 31) == 0);
      end
    end

    in_valid  = '0;
    flush     = '0;
    out_ready = '1;
    idle(20);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
